// File: rtl/tcp_echo_client.sv
// TCP client traffic source/checker: connects to a remote echo server, streams a seeded byte
// pattern into the raw TCP input and verifies the echoed bytes on the raw TCP output.
module tcp_echo_client #(
  parameter logic [31:0] REMOTE_IPV4     = {8'd192, 8'd168, 8'd1, 8'd213},
  parameter logic [15:0] REMOTE_PORT     = 16'd1000,
  parameter logic [31:0] TEST_BYTES      = 32'd65536,
  parameter logic [15:0] SEND_CHUNK      = 16'd1024,
  parameter logic [7:0]  SEED            = 8'h5A,
  parameter int unsigned CONNECT_TIMEOUT = 125000000,
  parameter int unsigned CONNECT_TRIES   = 5,
  parameter int unsigned RETRY_GAP       = 1000,
  parameter int unsigned DRAIN_TIMEOUT   = 125000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ready_i,
  input  logic        connected_i,
  output logic        connect_o,
  output logic [31:0] rem_ipv4_o,
  output logic [15:0] rem_port_o,
  input  logic        tcp_cts_i,
  output logic [7:0]  tcp_din_o,
  output logic        tcp_vin_o,
  output logic        tcp_snd_o,
  input  logic [7:0]  tcp_dout_i,
  input  logic        tcp_vout_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [31:0] tx_cnt_o,
  output logic [31:0] rx_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam logic [31:0] ConnLast  = 32'(CONNECT_TIMEOUT - 1);
  localparam logic [31:0] GapLast   = 32'(RETRY_GAP - 1);
  localparam logic [31:0] DrainLast = 32'(DRAIN_TIMEOUT - 1);
  localparam logic [31:0] TriesMax  = 32'(CONNECT_TRIES);
  localparam logic [15:0] ChunkLast = SEND_CHUNK - 16'd1;

  typedef enum logic [2:0] {StIdle, StConnect, StGap, StStream, StDrain, StDone, StFail} state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] tries_q, tries_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] chunk_q, chunk_d;
  logic        snd_q, snd_d;
  logic        tx_fire, rx_active, rx_complete;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      tries_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      chunk_q   <= '0;
      snd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tries_q   <= tries_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      chunk_q   <= chunk_d;
      snd_q     <= snd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tries_d   = tries_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    chunk_d   = chunk_q;
    snd_d     = 1'b0;

    // Transmit is gated by connected_i so a dropped link stops the byte count at once.
    tx_fire   = (state_q == StStream) && tcp_cts_i && connected_i && (tx_cnt_q < TEST_BYTES);
    rx_active = (state_q == StStream) || (state_q == StDrain);

    if (tx_fire) begin
      tx_cnt_d = tx_cnt_q + 32'd1;
      chunk_d  = (chunk_q == ChunkLast) ? 16'd0 : chunk_q + 16'd1;
      snd_d    = (chunk_q == ChunkLast) || (tx_cnt_q == TEST_BYTES - 32'd1);
    end

    if (rx_active && tcp_vout_i) begin
      rx_cnt_d = rx_cnt_q + 32'd1;
      if (((rx_cnt_q >= TEST_BYTES) || (tcp_dout_i != (rx_cnt_q[7:0] ^ SEED)))
          && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
    rx_complete = rx_cnt_d >= TEST_BYTES;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start_i && ready_i) begin
          state_d   = StConnect;
          timer_d   = '0;
          tries_d   = '0;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          err_cnt_d = '0;
          chunk_d   = '0;
        end
      end
      StConnect: begin
        timer_d = timer_q + 32'd1;
        if (connected_i) begin
          state_d = StStream;
          timer_d = '0;
        end else if (timer_q == ConnLast) begin
          timer_d = '0;
          tries_d = tries_q + 32'd1;
          state_d = (tries_q + 32'd1 == TriesMax) ? StFail : StGap;
        end
      end
      StGap: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == GapLast) begin
          state_d = StConnect;
          timer_d = '0;
        end
      end
      StStream: begin
        if ((tx_cnt_q == TEST_BYTES) && rx_complete) begin
          state_d = StDone;
        end else if (!connected_i) begin
          state_d = StFail;
        end else if (tx_cnt_q == TEST_BYTES) begin
          state_d = StDrain;
          timer_d = '0;
        end
      end
      StDrain: begin
        timer_d = timer_q + 32'd1;
        // Completion wins over a simultaneous link drop or timeout.
        if (rx_complete) begin
          state_d = StDone;
        end else if (!connected_i || (timer_q == DrainLast)) begin
          state_d = StFail;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign connect_o  = !rst_i && ((state_q == StConnect) || (state_q == StStream) ||
                                 (state_q == StDrain));
  assign rem_ipv4_o = REMOTE_IPV4;
  assign rem_port_o = REMOTE_PORT;
  assign tcp_din_o  = tx_cnt_q[7:0] ^ SEED;
  assign tcp_vin_o  = tx_fire && !rst_i;
  assign tcp_snd_o  = snd_q;
  assign busy_o     = (state_q == StConnect) || (state_q == StGap) || (state_q == StStream) ||
                      (state_q == StDrain);
  assign done_o     = (state_q == StDone);
  assign fail_o     = (state_q == StFail);
  assign tx_cnt_o   = tx_cnt_q;
  assign rx_cnt_o   = rx_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_tcp_echo_client.sv
// Bench for tcp_echo_client: delayed echo link model with an in-order transmit scoreboard.
module tb_tcp_echo_client;

  localparam logic [31:0] NBytes  = 32'd3000;
  localparam logic [7:0]  Seed    = 8'h5A;
  localparam int          ConnTo  = 100;
  localparam int          Tries   = 3;
  localparam int          Gap     = 20;
  localparam int          EchoDly = 20;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        connected_i = 1'b0;
  logic        connect_o;
  logic [31:0] rem_ipv4_o;
  logic [15:0] rem_port_o;
  logic        tcp_cts_i = 1'b1;
  logic [7:0]  tcp_din_o;
  logic        tcp_vin_o;
  logic        tcp_snd_o;
  logic [7:0]  tcp_dout_i = 8'h00;
  logic        tcp_vout_i = 1'b0;
  logic        busy_o, done_o, fail_o;
  logic [31:0] tx_cnt_o, rx_cnt_o;
  logic [15:0] err_cnt_o;

  always #5 clk = ~clk;

  tcp_echo_client #(
    .TEST_BYTES      (NBytes),
    .SEND_CHUNK      (16'd1024),
    .SEED            (Seed),
    .CONNECT_TIMEOUT (ConnTo),
    .CONNECT_TRIES   (Tries),
    .RETRY_GAP       (Gap),
    .DRAIN_TIMEOUT   (2000)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .ready_i     (ready_i),
    .connected_i (connected_i),
    .connect_o   (connect_o),
    .rem_ipv4_o  (rem_ipv4_o),
    .rem_port_o  (rem_port_o),
    .tcp_cts_i   (tcp_cts_i),
    .tcp_din_o   (tcp_din_o),
    .tcp_vin_o   (tcp_vin_o),
    .tcp_snd_o   (tcp_snd_o),
    .tcp_dout_i  (tcp_dout_i),
    .tcp_vout_i  (tcp_vout_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .tx_cnt_o    (tx_cnt_o),
    .rx_cnt_o    (rx_cnt_o),
    .err_cnt_o   (err_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_tx_q[$];
  logic [7:0] sent_q[$];
  int         due_q[$];
  int         snd_log[$];
  int         exp_snd_q[$];
  int         echo_idx = 0;
  int         corrupt_idx = -1;
  bit         echo_en = 1'b0;
  bit         cts_toggle = 1'b0;
  logic [7:0] echo_b, exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Link model: inputs change on the falling edge, DUT outputs are sampled 1 ns later.
  always @(negedge clk) begin
    tcp_vout_i = 1'b0;
    if (echo_en && (due_q.size() > 0) && (due_q[0] <= cyc)) begin
      echo_b = sent_q.pop_front();
      void'(due_q.pop_front());
      if (echo_idx == corrupt_idx) echo_b = echo_b ^ 8'h01;
      echo_idx++;
      tcp_dout_i = echo_b;
      tcp_vout_i = 1'b1;
    end
    tcp_cts_i = cts_toggle ? ~tcp_cts_i : 1'b1;
    #1;
    if (tcp_snd_o) snd_log.push_back(int'(tx_cnt_o));
    if (tcp_vin_o) begin
      checks++;
      if (!tcp_cts_i) begin
        errors++;
        $display("FAIL vin_without_cts: tcp_vin=1 cts=%0b required cts=1", tcp_cts_i);
      end
      checks++;
      if (exp_tx_q.size() == 0) begin
        errors++;
        $display("FAIL extra_tx_byte: got %02h required no byte", tcp_din_o);
      end else begin
        exp_b = exp_tx_q.pop_front();
        if (tcp_din_o !== exp_b) begin
          errors++;
          $display("FAIL tx_byte: got %02h required %02h", tcp_din_o, exp_b);
        end
      end
      sent_q.push_back(tcp_din_o);
      due_q.push_back(cyc + EchoDly);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_tx_q.delete();
    sent_q.delete();
    due_q.delete();
    snd_log.delete();
    exp_snd_q.delete();
    echo_idx = 0;
  endtask

  // Start a run with the expected byte stream queued; link comes up 10 cycles after start.
  task automatic launch(input int corrupt, input bit toggle);
    model_clear();
    for (int n = 0; n < int'(NBytes); n++) exp_tx_q.push_back(8'(n) ^ Seed);
    corrupt_idx = corrupt;
    cts_toggle  = toggle;
    echo_en     = 1'b1;
    connected_i = 1'b0;
    ready_i     = 1'b1;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    connected_i = 1'b1;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o || fail_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if ({connect_o, tcp_vin_o, tcp_snd_o, busy_o, done_o, fail_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %06b required 000000",
               {connect_o, tcp_vin_o, tcp_snd_o, busy_o, done_o, fail_o});
    end
    checks++;
    if ({tx_cnt_o, rx_cnt_o, err_cnt_o} !== 80'd0) begin
      errors++;
      $display("FAIL reset_counters: tx=%0d rx=%0d err=%0d required 0", tx_cnt_o, rx_cnt_o,
               err_cnt_o);
    end
    checks++;
    if (rem_ipv4_o !== 32'hC0A801D5 || rem_port_o !== 16'd1000) begin
      errors++;
      $display("FAIL remote_addr: got %08h:%0d required c0a801d5:1000", rem_ipv4_o, rem_port_o);
    end
    ready_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || connect_o !== 1'b0) begin
      errors++;
      $display("FAIL start_not_ready: busy=%0b connect=%0b required 0 0", busy_o, connect_o);
    end
  endtask

  task automatic test_stream_echo();
    bit ok;
    int s;
    launch(-1, 1'b0);
    exp_snd_q = '{1024, 2048, 3000};
    checks++;
    if (connect_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL connect_phase: connect=%0b busy=%0b required 1 1", connect_o, busy_o);
    end
    wait_end(20000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stream_timeout: done=%0b fail=%0b required done within budget", done_o,
               fail_o);
    end
    checks++;
    if (done_o !== 1'b1 || fail_o !== 1'b0 || connect_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_status: done=%0b fail=%0b connect=%0b busy=%0b required 1 0 0 0",
               done_o, fail_o, connect_o, busy_o);
    end
    checks++;
    if (tx_cnt_o !== NBytes || rx_cnt_o !== NBytes || err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL stream_counts: tx=%0d rx=%0d err=%0d required 3000 3000 0", tx_cnt_o,
               rx_cnt_o, err_cnt_o);
    end
    checks++;
    if (exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL stream_missing: %0d bytes unsent required 0", exp_tx_q.size());
    end
    while (exp_snd_q.size() > 0) begin
      s = exp_snd_q.pop_front();
      checks++;
      if (snd_log.size() == 0) begin
        errors++;
        $display("FAIL snd_pulse: got none required pulse at tx_cnt=%0d", s);
      end else if (snd_log[0] != s) begin
        errors++;
        $display("FAIL snd_pulse: got tx_cnt=%0d required %0d", snd_log[0], s);
        void'(snd_log.pop_front());
      end else begin
        void'(snd_log.pop_front());
      end
    end
    checks++;
    if (snd_log.size() != 0) begin
      errors++;
      $display("FAIL snd_extra: got %0d extra pulses required 0", snd_log.size());
    end
    connected_i = 1'b0;
  endtask

  task automatic test_cts_toggle();
    bit ok;
    launch(-1, 1'b1);
    wait_end(20000, ok);
    checks++;
    if (!ok || done_o !== 1'b1) begin
      errors++;
      $display("FAIL cts_done: done=%0b fail=%0b required done=1", done_o, fail_o);
    end
    checks++;
    if (tx_cnt_o !== NBytes || rx_cnt_o !== NBytes || err_cnt_o !== 16'd0 ||
        exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL cts_counts: tx=%0d rx=%0d err=%0d left=%0d required 3000 3000 0 0",
               tx_cnt_o, rx_cnt_o, err_cnt_o, exp_tx_q.size());
    end
    cts_toggle  = 1'b0;
    connected_i = 1'b0;
  endtask

  task automatic test_connect_timeout();
    int hi[$];
    int lo[$];
    int run;
    int guard;
    logic lvl;
    model_clear();
    echo_en     = 1'b0;
    connected_i = 1'b0;
    ready_i     = 1'b1;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    lvl = 1'b1;
    run = 0;
    guard = 0;
    while (!fail_o && guard < 2000) begin
      if (connect_o == lvl) run++;
      else begin
        if (lvl) hi.push_back(run);
        else lo.push_back(run);
        lvl = connect_o;
        run = 1;
      end
      tick();
      guard++;
    end
    if (lvl) hi.push_back(run);
    else lo.push_back(run);
    checks++;
    if (fail_o !== 1'b1 || connect_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: fail=%0b connect=%0b done=%0b busy=%0b required 1 0 0 0",
               fail_o, connect_o, done_o, busy_o);
    end
    checks++;
    if (hi.size() != Tries || lo.size() != Tries - 1) begin
      errors++;
      $display("FAIL timeout_windows: got %0d high %0d low required %0d high %0d low",
               hi.size(), lo.size(), Tries, Tries - 1);
    end
    foreach (hi[i]) begin
      checks++;
      if (hi[i] != ConnTo) begin
        errors++;
        $display("FAIL connect_window: window %0d got %0d cycles required %0d", i, hi[i], ConnTo);
      end
    end
    foreach (lo[i]) begin
      checks++;
      if (lo[i] != Gap) begin
        errors++;
        $display("FAIL retry_gap: gap %0d got %0d cycles required %0d", i, lo[i], Gap);
      end
    end
  endtask

  task automatic test_corrupt_echo();
    bit ok;
    launch(500, 1'b0);
    wait_end(20000, ok);
    checks++;
    if (!ok || done_o !== 1'b1 || fail_o !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_done: done=%0b fail=%0b required 1 0", done_o, fail_o);
    end
    checks++;
    if (err_cnt_o !== 16'd1 || rx_cnt_o !== NBytes) begin
      errors++;
      $display("FAIL corrupt_counts: err=%0d rx=%0d required 1 3000", err_cnt_o, rx_cnt_o);
    end
    corrupt_idx = -1;
    connected_i = 1'b0;
  endtask

  task automatic test_link_drop();
    int guard;
    launch(-1, 1'b0);
    guard = 0;
    while (tx_cnt_o != 32'd1500 && guard < 5000) begin
      tick();
      guard++;
    end
    checks++;
    if (tx_cnt_o !== 32'd1500) begin
      errors++;
      $display("FAIL drop_reach: tx=%0d required 1500", tx_cnt_o);
    end
    connected_i = 1'b0;
    tick();
    checks++;
    if (fail_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_status: fail=%0b done=%0b busy=%0b required 1 0 0", fail_o, done_o,
               busy_o);
    end
    checks++;
    if (tcp_vin_o !== 1'b0 || connect_o !== 1'b0 || tx_cnt_o !== 32'd1500) begin
      errors++;
      $display("FAIL drop_outputs: vin=%0b connect=%0b tx=%0d required 0 0 1500", tcp_vin_o,
               connect_o, tx_cnt_o);
    end
    repeat (5) tick();
    checks++;
    if (tx_cnt_o !== 32'd1500 || fail_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_frozen: tx=%0d fail=%0b required 1500 1", tx_cnt_o, fail_o);
    end
    echo_en = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    int guard;
    launch(-1, 1'b0);
    guard = 0;
    while (tx_cnt_o != NBytes && guard < 5000) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (busy_o !== 1'b1 || rx_cnt_o >= NBytes) begin
      errors++;
      $display("FAIL drain_entry: busy=%0b rx=%0d required busy=1 rx<3000", busy_o, rx_cnt_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (connect_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_connect_drop: connect=%0b required 0", connect_o);
    end
    tick();
    checks++;
    if ({connect_o, tcp_vin_o, tcp_snd_o, busy_o, done_o, fail_o} !== 6'b0 ||
        {tx_cnt_o, rx_cnt_o, err_cnt_o} !== 80'd0) begin
      errors++;
      $display("FAIL rst_in_drain: flags=%06b tx=%0d rx=%0d err=%0d required all 0",
               {connect_o, tcp_vin_o, tcp_snd_o, busy_o, done_o, fail_o}, tx_cnt_o, rx_cnt_o,
               err_cnt_o);
    end
    rst_i       = 1'b0;
    echo_en     = 1'b0;
    connected_i = 1'b0;
    repeat (3) tick();
    launch(-1, 1'b0);
    wait_end(20000, ok);
    checks++;
    if (!ok || done_o !== 1'b1 || tx_cnt_o !== NBytes || rx_cnt_o !== NBytes ||
        err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL rerun_after_rst: done=%0b tx=%0d rx=%0d err=%0d required 1 3000 3000 0",
               done_o, tx_cnt_o, rx_cnt_o, err_cnt_o);
    end
    connected_i = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion before 900 us");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream_echo();
    test_cts_toggle();
    test_connect_timeout();
    test_corrupt_echo();
    test_link_drop();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
